// File: rtl/reduce_pkg.sv
// Shared definitions for the reduction gate pipeline.
//   op_t       : operation encoding carried alongside each beat
//   identity() : padding value that leaves a reduction unchanged
//   gate2()    : the 2-input gate used at every tree node
// NAND beats are reduced with the AND gate. The inversion is applied once,
// after the last tree level.
package reduce_pkg;

    typedef enum logic [1:0] {
        OP_AND  = 2'b00,
        OP_OR   = 2'b01,
        OP_XOR  = 2'b10,
        OP_NAND = 2'b11
    } op_t;

    localparam int CNT_W = 16;

    // Identity element of the reduction: 1 for AND/NAND, 0 for OR/XOR.
    function automatic logic identity(input op_t op);
        return (op == OP_AND) || (op == OP_NAND);
    endfunction

    // One tree node. NAND uses the plain AND here.
    function automatic logic gate2(input op_t op, input logic a, input logic b);
        logic r;
        case (op)
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            default: r = a & b;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/reduce_stage.sv
// One level of the reduction tree: pairwise gate of a W_IN-bit vector into a
// W_IN/2-bit vector, registered together with the beat's valid and op.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   stall               freezes every register of this level
//   in_valid/in_op      qualifier and operation of the incoming beat
//   in_vec  [W_IN-1:0]  operand vector of this level
//   out_valid/out_op    registered qualifier and operation
//   out_vec [W_IN/2-1:0] registered gate outputs
// Data and op load only when a valid beat is taken, so the last valid
// result stays visible through bubbles.
module reduce_stage
    import reduce_pkg::*;
#(
    parameter int W_IN = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              in_valid,
    input  op_t               in_op,
    input  logic [W_IN-1:0]   in_vec,
    output logic              out_valid,
    output op_t               out_op,
    output logic [W_IN/2-1:0] out_vec
);

    localparam int W_OUT = W_IN / 2;

    logic [W_OUT-1:0] gate_vec;
    logic [W_OUT-1:0] vec_reg;
    logic             valid_reg;
    op_t              op_reg;

    generate
        for (genvar gi = 0; gi < W_OUT; gi++) begin : g_gate
            assign gate_vec[gi] = gate2(in_op, in_vec[2*gi], in_vec[2*gi+1]);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg <= 1'b0;
            op_reg    <= OP_AND;
            vec_reg   <= '0;
        end else if (!stall) begin
            valid_reg <= in_valid;
            if (in_valid) begin
                op_reg  <= in_op;
                vec_reg <= gate_vec;
            end
        end
    end

    assign out_valid = valid_reg;
    assign out_op    = op_reg;
    assign out_vec   = vec_reg;

endmodule

// File: rtl/reduce_gate_pipe.sv
// Pipelined N-input AND/OR/XOR/NAND reduction. There is one register level
// per tree level, so the latency is LAT = ceil(log2(N)) cycles.
// Optional feature: define REDUCE_CNT_EN to add res_cnt. It is a saturating
// count of valid results with y=1.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   in_valid       in_data/in_op qualify this cycle
//   in_data [N-1:0] operand bits
//   in_op   [1:0]  00 AND, 01 OR, 10 XOR, 11 NAND
//   stall          freezes the whole pipeline; beats offered meanwhile are dropped
//   out_valid      y carries a fresh result this cycle
//   y              reduction result; holds the last valid value otherwise
//   res_cnt [15:0] (REDUCE_CNT_EN only) count of results with y=1
module reduce_gate_pipe
    import reduce_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [N-1:0] in_data,
    input  logic [1:0]   in_op,
    input  logic         stall,
    output logic         out_valid,
    output logic         y
`ifdef REDUCE_CNT_EN
    ,
    output logic [CNT_W-1:0] res_cnt
`endif
);

    localparam int LAT   = $clog2(N);
    localparam int P     = 1 << LAT;   // leaves after padding
    localparam int BUS_W = 2 * P - 1;  // all tree levels packed end to end

    // Level l occupies P>>l bits starting at 2P - 2*(P>>l). Level 0 holds
    // the padded leaves, and level LAT holds the single root bit at BUS_W-1.
    logic [BUS_W-1:0] tree_bus;
    logic [LAT:0]     valid_bus;
    op_t              op_bus [0:LAT];

    assign valid_bus[0] = in_valid;
    assign op_bus[0]    = op_t'(in_op);

    generate
        for (genvar gi = 0; gi < P; gi++) begin : g_leaf
            if (gi < N) begin : g_data
                assign tree_bus[gi] = in_data[gi];
            end else begin : g_pad
                assign tree_bus[gi] = identity(op_bus[0]);
            end
        end

        for (genvar gi = 0; gi < LAT; gi++) begin : g_level
            localparam int W     = P >> gi;
            localparam int OFF_I = 2 * P - 2 * W;
            localparam int OFF_O = 2 * P - W;

            reduce_stage #(
                .W_IN(W)
            ) u_stage (
                .clk      (clk),
                .rst_n    (rst_n),
                .stall    (stall),
                .in_valid (valid_bus[gi]),
                .in_op    (op_bus[gi]),
                .in_vec   (tree_bus[OFF_I +: W]),
                .out_valid(valid_bus[gi+1]),
                .out_op   (op_bus[gi+1]),
                .out_vec  (tree_bus[OFF_O +: W/2])
            );
        end
    endgenerate

    // The root and its op are held together, so the NAND inversion applied
    // here stays consistent with the last valid beat during bubbles.
    // After reset the root is 0 and the op is AND, so y is 0.
    assign out_valid = valid_bus[LAT];
    assign y         = tree_bus[BUS_W-1] ^ (op_bus[LAT] == OP_NAND);

`ifdef REDUCE_CNT_EN
    logic [CNT_W-1:0] cnt_reg;

    // Counting only on non-stalled edges makes a result that is frozen at the
    // output increment the count exactly once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (!stall && out_valid && y && (cnt_reg != {CNT_W{1'b1}})) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign res_cnt = cnt_reg;
`endif

endmodule

// File: tb/tb_reduce_gate_pipe.sv
module tb_reduce_gate_pipe;

    localparam logic [1:0] AND_OP  = 2'b00;
    localparam logic [1:0] OR_OP   = 2'b01;
    localparam logic [1:0] XOR_OP  = 2'b10;
    localparam logic [1:0] NAND_OP = 2'b11;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, stall;
    logic       iv4, ov4, y4;
    logic [3:0] d4;
    logic [1:0] o4;
    logic       iv5, ov5, y5;
    logic [4:0] d5;
    logic [1:0] o5;
`ifdef REDUCE_CNT_EN
    logic [15:0] cnt4, cnt5;
`endif

    reduce_gate_pipe #(.N(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_data(d4), .in_op(o4),
        .stall(stall), .out_valid(ov4), .y(y4)
`ifdef REDUCE_CNT_EN
        , .res_cnt(cnt4)
`endif
    );

    reduce_gate_pipe #(.N(5)) dut5 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv5), .in_data(d5), .in_op(o5),
        .stall(stall), .out_valid(ov5), .y(y5)
`ifdef REDUCE_CNT_EN
        , .res_cnt(cnt5)
`endif
    );

    typedef struct {
        bit y;
        int at;
    } exp_t;

    exp_t q4[$];
    exp_t q5[$];
    int   total = 0;
    int   bad   = 0;
    int   adv   = 0;   // count of edges that advanced the pipeline
    bit   held  = 1'b1; // last edge was stalled or in reset

    always @(posedge clk) begin
        held <= stall || !rst_n;
        if (rst_n && !stall) adv <= adv + 1;
    end

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, req);
        end
    endtask

    task automatic pop_check(input string name, input logic yv, ref exp_t q[$]);
        exp_t e;
        if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s_extra: got out_valid=1 y=%0d want no result", name, yv);
        end else begin
            e = q.pop_front();
            check({name, "_y"}, yv, e.y);
            check({name, "_at"}, adv, e.at);
        end
    endtask

    task automatic monitor();
        logic pv4 = 1'b0, py4 = 1'b0, pv5 = 1'b0, py5 = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (held) begin
                    if (ov4 || pv4) begin
                        check("hold4_v", ov4, pv4);
                        check("hold4_y", y4, py4);
                    end
                    if (ov5 || pv5) begin
                        check("hold5_v", ov5, pv5);
                        check("hold5_y", y5, py5);
                    end
                end else begin
                    if (ov4) pop_check("n4", y4, q4);
                    if (ov5) pop_check("n5", y5, q5);
                end
            end
            pv4 = ov4; py4 = y4; pv5 = ov5; py5 = y5;
        end
    endtask

    task automatic beat4(input logic [3:0] d, input logic [1:0] op, input bit e);
        iv4 = 1'b1; d4 = d; o4 = op;
        if (!stall) q4.push_back('{y: e, at: adv + 2});
        @(posedge clk); #1;
        iv4 = 1'b0; d4 = '0; o4 = AND_OP;
    endtask

    task automatic beat5(input logic [4:0] d, input logic [1:0] op, input bit e);
        iv5 = 1'b1; d5 = d; o5 = op;
        if (!stall) q5.push_back('{y: e, at: adv + 3});
        @(posedge clk); #1;
        iv5 = 1'b0; d5 = '0; o5 = AND_OP;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0;
        iv4 = 1'b0; d4 = '0; o4 = AND_OP;
        iv5 = 1'b1; d5 = 5'b11111; o5 = OR_OP; // ignored while in reset
        fork
            monitor();
        join_none

        repeat (2) @(posedge clk);
        #1;
        check("rst_v4", ov4, 0);
        check("rst_y4", y4, 0);
        check("rst_v5", ov5, 0);
        check("rst_y5", y5, 0);
`ifdef REDUCE_CNT_EN
        check("rst_cnt4", cnt4, 0);
`endif
        iv5 = 1'b0; d5 = '0; o5 = AND_OP;
        rst_n = 1'b1;
        idle(1);

        // N=4: basic AND, then back-to-back mixed ops
        beat4(4'b1111, AND_OP, 1'b1);
        beat4(4'b1110, AND_OP, 1'b0);
        idle(3);
        beat4(4'b0001, OR_OP,   1'b1);
        beat4(4'b0111, XOR_OP,  1'b1);
        beat4(4'b1111, NAND_OP, 1'b0);
        beat4(4'b1110, NAND_OP, 1'b1);
        beat4(4'b0000, OR_OP,   1'b0);
        beat4(4'b1010, XOR_OP,  1'b0);
        beat4(4'b0000, NAND_OP, 1'b1);
        idle(3);

        // N=5: three padding leaves, identity depends on the op
        beat5(5'b11111, AND_OP,  1'b1);
        beat5(5'b00000, OR_OP,   1'b0);
        beat5(5'b10000, XOR_OP,  1'b1);
        beat5(5'b01111, AND_OP,  1'b0);
        beat5(5'b11111, NAND_OP, 1'b0);
        beat5(5'b11110, NAND_OP, 1'b1);
        beat5(5'b10101, XOR_OP,  1'b1);
        beat5(5'b00001, OR_OP,   1'b1);
        idle(4);

        // Stall with two beats in flight. The beat offered during the stall is dropped.
        beat4(4'b1011, XOR_OP,  1'b1);
        beat4(4'b0000, AND_OP,  1'b0);
        beat4(4'b1110, NAND_OP, 1'b1);
        stall = 1'b1;
        iv4 = 1'b1; d4 = 4'b0000; o4 = OR_OP;
        iv5 = 1'b1; d5 = 5'b11111; o5 = AND_OP;
        idle(3);
        stall = 1'b0;
        iv4 = 1'b0; iv5 = 1'b0; d5 = '0;
        idle(4);
        check("bubble_v4", ov4, 0);
        check("bubble_y4_held", y4, 1);
        check("bubble_v5", ov5, 0);

        // Reset with beats in flight
        beat4(4'b1111, AND_OP, 1'b1);
        beat4(4'b0001, OR_OP,  1'b1);
        beat5(5'b11111, AND_OP, 1'b1);
        rst_n = 1'b0;
        q4.delete();
        q5.delete();
        iv4 = 1'b1; d4 = 4'b1111; o4 = AND_OP;
        #1;
        check("async_rst_v4", ov4, 0);
        check("async_rst_y4", y4, 0);
        @(posedge clk); #1;
        iv4 = 1'b0; d4 = '0;
        rst_n = 1'b1;
        idle(4);
        beat4(4'b0111, XOR_OP, 1'b1);
        beat5(5'b00000, NAND_OP, 1'b1);
        idle(4);

`ifdef REDUCE_CNT_EN
        repeat (70000) beat4(4'b1111, AND_OP, 1'b1);
        idle(3);
        check("cnt4_sat", cnt4, 16'hFFFF);
`endif

        for (int i = 0; i < 20 && (q4.size() != 0 || q5.size() != 0); i++) idle(1);
        check("drain_q4", q4.size(), 0);
        check("drain_q5", q5.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
